// File: rtl/cpu_clock_sched.sv
// cpu_clock_sched
//
// CPU and timer clock-enable scheduler driven from a single master clock.
// A phase counter divides the master clock down to CPU cycles at one of two
// speeds (fast / slow); speed changes are requested with a strobe and only
// take effect at the next CPU cycle boundary so a CPU cycle is never cut
// short. An independent prescaler produces the timer tick.
//
// Optional feature (macro CPU_CLOCK_SCHED_WAIT_EN):
//   When defined, wait_req stretches the CPU cycle by holding the boundary
//   (phase 0) until wait_req drops. When undefined, wait_req is ignored and
//   no stall logic exists.
//
// Parameters:
//   FAST_DIV   master clocks per CPU cycle in fast mode
//   SLOW_DIV   master clocks per CPU cycle in slow mode
//   TIMER_DIV  master clocks per timer tick
//
// Ports:
//   clk           master clock, rising edge
//   reset         synchronous, active-high reset
//   speed_valid   one-cycle speed-change request strobe
//   speed_req     requested speed, 1 = fast, 0 = slow
//   wait_req      bus wait request (only used with CPU_CLOCK_SCHED_WAIT_EN)
//   cpu_clk_en    one-clk CPU cycle enable
//   timer_clk_en  one-clk timer prescaler tick
//   speed_fast    speed indication decoded from the speed FSM
//   speed_busy    a speed change is pending
//   speed_ack     one-clk pulse when a requested speed takes effect

module cpu_clock_sched #(
    parameter int FAST_DIV  = 3,
    parameter int SLOW_DIV  = 12,
    parameter int TIMER_DIV = 3072
) (
    input  logic clk,
    input  logic reset,
    input  logic speed_valid,
    input  logic speed_req,
    input  logic wait_req,
    output logic cpu_clk_en,
    output logic timer_clk_en,
    output logic speed_fast,
    output logic speed_busy,
    output logic speed_ack
);

    localparam int MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int PHASE_W = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam int TIMER_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    localparam logic [PHASE_W-1:0] FAST_RELOAD  = PHASE_W'(FAST_DIV - 1);
    localparam logic [PHASE_W-1:0] SLOW_RELOAD  = PHASE_W'(SLOW_DIV - 1);
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(TIMER_DIV - 1);

    typedef enum logic [1:0] {
        SLOW      = 2'd0,
        FAST      = 2'd1,
        PEND_FAST = 2'd2,
        PEND_SLOW = 2'd3
    } state_t;

    state_t               state;
    logic [PHASE_W-1:0]   phase;
    logic [TIMER_W-1:0]   timer_cnt;
    logic                 boundary;
    logic                 stall;
    logic                 pending;
    logic [PHASE_W-1:0]   reload;

    assign boundary = (phase == '0);

`ifdef CPU_CLOCK_SCHED_WAIT_EN
    // A wait request only matters at the boundary: it freezes phase at 0
    // and defers the CPU enable (and any pending speed change with it).
    assign stall = boundary && wait_req;
`else
    logic wait_req_unused;
    assign wait_req_unused = wait_req;
    assign stall = 1'b0;
`endif

    assign pending = (state == PEND_FAST) || (state == PEND_SLOW);

    // The enable and ack are combinational so the ack lands in the very
    // cycle the new divisor is loaded, and a same-cycle wait_req can
    // suppress the enable.
    assign cpu_clk_en   = !reset && boundary && !stall;
    assign timer_clk_en = !reset && (timer_cnt == '0);
    assign speed_ack    = cpu_clk_en && pending;
    assign speed_busy   = !reset && pending;
    assign speed_fast   = !reset && ((state == FAST) || (state == PEND_SLOW));

    // In a pending state the reload already uses the divisor of the target
    // speed, which is what makes the change take effect at this boundary.
    always_comb begin
        reload = SLOW_RELOAD;
        case (state)
            FAST, PEND_FAST: reload = FAST_RELOAD;
            default:         reload = SLOW_RELOAD;
        endcase
    end

    // Phase counter, timer prescaler and speed FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SLOW;
            phase     <= '0;
            timer_cnt <= '0;
        end else begin
            if (timer_cnt == '0) begin
                timer_cnt <= TIMER_RELOAD;
            end else begin
                timer_cnt <= timer_cnt - 1'b1;
            end

            if (cpu_clk_en) begin
                phase <= reload;
            end else if (!boundary) begin
                phase <= phase - 1'b1;
            end

            case (state)
                SLOW, FAST: begin
                    if (speed_valid) begin
                        state <= speed_req ? PEND_FAST : PEND_SLOW;
                    end
                end
                PEND_FAST: begin
                    if (cpu_clk_en) begin
                        state <= FAST;
                    end
                end
                PEND_SLOW: begin
                    if (cpu_clk_en) begin
                        state <= SLOW;
                    end
                end
                default: state <= SLOW;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_clock_sched.sv
// tb_cpu_clock_sched
//
// Self-checking bench for cpu_clock_sched. Stimulus is applied one master
// clock at a time; a time-based reference model (cycle counts since reset
// and the time the next CPU boundary is due) predicts every output and
// pushes the prediction into a queue, which a monitor on the falling edge
// pops and compares against the DUT. Directed scenarios additionally check
// fixed cycle numbers against constants.
//
// Build with +define+CPU_CLOCK_SCHED_WAIT_EN to exercise the stall feature.

module tb_cpu_clock_sched;

    localparam int FAST_DIV  = 3;
    localparam int SLOW_DIV  = 12;
    localparam int TIMER_DIV = 3072;

`ifdef CPU_CLOCK_SCHED_WAIT_EN
    localparam bit WAIT_ON = 1'b1;
`else
    localparam bit WAIT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic speed_valid = 1'b0;
    logic speed_req = 1'b0;
    logic wait_req = 1'b0;
    logic cpu_clk_en;
    logic timer_clk_en;
    logic speed_fast;
    logic speed_busy;
    logic speed_ack;

    int checks = 0;
    int errors = 0;

    // Expected outputs packed as {cpu_clk_en, timer_clk_en, speed_fast, speed_busy, speed_ack}.
    logic [4:0] exp_q[$];

    // Reference model state.
    int unsigned m_cyc = 0;
    int unsigned m_due = 0;
    bit          m_fast = 1'b0;
    bit          m_pend = 1'b0;
    bit          m_target = 1'b0;
    int          cur = 0;

    cpu_clock_sched #(
        .FAST_DIV (FAST_DIV),
        .SLOW_DIV (SLOW_DIV),
        .TIMER_DIV(TIMER_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .speed_valid (speed_valid),
        .speed_req   (speed_req),
        .wait_req    (wait_req),
        .cpu_clk_en  (cpu_clk_en),
        .timer_clk_en(timer_clk_en),
        .speed_fast  (speed_fast),
        .speed_busy  (speed_busy),
        .speed_ack   (speed_ack)
    );

    always #5 clk = ~clk;

    // Drive one master clock of inputs and push the predicted outputs.
    // "cur" is the cycle number (since reset release) of the cycle driven.
    task automatic applyStimulus(input logic rst, input logic sv, input logic sr, input logic wr);
        logic [4:0] e;
        bit en;
        bit busy;
        @(posedge clk);
        #1;
        reset       = rst;
        speed_valid = sv;
        speed_req   = sr;
        wait_req    = wr;
        if (rst) begin
            e        = '0;
            m_cyc    = 0;
            m_due    = 0;
            m_fast   = 1'b0;
            m_pend   = 1'b0;
            m_target = 1'b0;
            cur      = -1;
        end else begin
            cur  = int'(m_cyc);
            busy = m_pend;
            en   = (m_cyc >= m_due) && !(WAIT_ON && wr);
            // The indicator follows the FSM state: while pending it shows the
            // opposite of the target, otherwise the active speed.
            e = {en, ((m_cyc % TIMER_DIV) == 0), (busy ? !m_target : m_fast), busy, (en && busy)};
            if (en) begin
                if (m_pend) begin
                    m_fast = m_target;
                    m_pend = 1'b0;
                end
                m_due = m_cyc + (m_fast ? FAST_DIV : SLOW_DIV);
            end
            if (sv && !busy) begin
                m_pend   = 1'b1;
                m_target = sr;
            end
            m_cyc = m_cyc + 1;
        end
        exp_q.push_back(e);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cur, act, exp);
        end
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: compares the DUT against the oldest prediction.
    always @(negedge clk) begin
        logic [4:0] e;
        logic [4:0] a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {cpu_clk_en, timer_clk_en, speed_fast, speed_busy, speed_ack};
            checks++;
            if (a !== e) begin
                errors++;
                $display("[TB] FAIL scoreboard t=%0t cpu/tmr/fast/busy/ack got %b expected %b", $time, a, e);
            end
        end
    end

    initial begin
        // Reset release with no requests.
        resetCycles(3);
        for (int c = 0; c <= 3075; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (c < 30) begin
                checkOutput("idle_cpu_en", cpu_clk_en, (c == 0 || c == 12 || c == 24));
                checkOutput("idle_fast", speed_fast, 1'b0);
            end
            if (c == 0 || c == 1 || c == 3071 || c == 3072)
                checkOutput("idle_timer_en", timer_clk_en, (c == 0 || c == 3072));
        end

        // Slow to fast request at cycle 5.
        resetCycles(2);
        for (int c = 0; c <= 20; c++) begin
            applyStimulus(1'b0, (c == 5), 1'b1, 1'b0);
            checkOutput("tofast_busy", speed_busy, (c >= 6 && c <= 12));
            checkOutput("tofast_ack", speed_ack, (c == 12));
            checkOutput("tofast_cpu_en", cpu_clk_en, (c == 0 || c == 12 || c == 15 || c == 18));
        end

        // In fast mode: slow request, then a fast request while pending.
        resetCycles(2);
        for (int c = 0; c <= 45; c++) begin
            applyStimulus(1'b0, (c == 1 || c == 16 || c == 17), (c != 16), 1'b0);
            if (c >= 13) begin
                checkOutput("second_req_cpu_en", cpu_clk_en, (c == 15 || c == 18 || c == 30 || c == 42));
                checkOutput("second_req_ack", speed_ack, (c == 18));
            end
            if (c >= 19) checkOutput("second_req_slow", speed_fast, 1'b0);
        end

        // Wait request in cycles 12-14 of slow mode.
        resetCycles(2);
        for (int c = 0; c <= 30; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, (c >= 12 && c <= 14));
            checkOutput("wait_cpu_en", cpu_clk_en,
                        WAIT_ON ? (c == 0 || c == 15 || c == 27) : (c == 0 || c == 12 || c == 24));
        end

        // Reset while a fast request is pending.
        resetCycles(2);
        for (int c = 0; c <= 7; c++) begin
            applyStimulus(1'b0, (c == 3), 1'b1, 1'b0);
            checkOutput("rst_pend_ack", speed_ack, 1'b0);
            if (c == 5) checkOutput("rst_pend_busy_before", speed_busy, 1'b1);
        end
        resetCycles(2);
        for (int c = 0; c <= 30; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("rst_pend_ack_after", speed_ack, 1'b0);
            checkOutput("rst_pend_busy_after", speed_busy, 1'b0);
            checkOutput("rst_pend_cpu_en", cpu_clk_en, (c % 12 == 0));
        end

        // Randomized traffic against the reference model only.
        resetCycles(2);
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 599) == 0),
                          ($urandom_range(0, 11) == 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_clock_sched.md
CPU_CLOCK_SCHED -- requirements
Module: cpu_clock_sched

Interface
REQ-001 The module SHALL have parameter FAST_DIV, default 3, giving the master-clock cycles per CPU cycle in fast mode (7.16 MHz).
REQ-002 The module SHALL have parameter SLOW_DIV, default 12, giving the master-clock cycles per CPU cycle in slow mode (1.79 MHz).
REQ-003 The module SHALL have parameter TIMER_DIV, default 3072, giving the master-clock cycles per timer tick (7.16 MHz / 1024).
REQ-004 The module SHALL have port clk, input, 1 bit, master clock (21.47 MHz); all logic is rising-edge.
REQ-005 The module SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-006 The module SHALL have port speed_valid, input, 1 bit, a one-cycle speed-change request strobe (CSH/CSL).
REQ-007 The module SHALL have port speed_req, input, 1 bit, the requested speed qualified by speed_valid (1 = fast, 0 = slow).
REQ-008 The module SHALL have port wait_req, input, 1 bit, a bus wait request that stretches the current CPU cycle.
REQ-009 The module SHALL have port cpu_clk_en, output, 1 bit, a one-clk CPU cycle enable.
REQ-010 The module SHALL have port timer_clk_en, output, 1 bit, a one-clk timer prescaler tick.
REQ-011 The module SHALL have port speed_fast, output, 1 bit, the current active speed (1 = fast).
REQ-012 The module SHALL have port speed_busy, output, 1 bit, asserted while a speed change is pending.
REQ-013 The module SHALL have port speed_ack, output, 1 bit, a one-clk pulse when a requested speed takes effect.

Function
REQ-014 The module SHALL hold a phase counter, width $clog2(max(FAST_DIV,SLOW_DIV)); a CPU boundary is phase==0.
REQ-015 The module SHALL assert cpu_clk_en in a cycle exactly when reset is low, phase==0 and the cycle is not stalled (REQ-022).
REQ-016 When phase==0 and cpu_clk_en asserts, the module SHALL reload phase with the active divisor minus 1; otherwise, with phase nonzero, it SHALL decrement phase.
REQ-017 The FSM states SHALL be SLOW, FAST, PEND_FAST and PEND_SLOW, with speed_fast=1 in FAST and PEND_SLOW only.
REQ-018 On speed_valid in SLOW or FAST, the FSM SHALL go to PEND_FAST if speed_req=1, or to PEND_SLOW otherwise; speed_busy=1 in both PEND states.
REQ-019 On speed_valid in either PEND state, the module SHALL ignore the request: no state change and no ack.
REQ-020 In a PEND state, on the next cycle with cpu_clk_en=1, the reload SHALL use the new divisor, the FSM SHALL move to FAST or SLOW, and speed_ack SHALL pulse in that same cycle.
REQ-021 A request for the current speed SHALL still pass through PEND and ack at the next boundary, with the divisor unchanged.
REQ-022 A cycle is stalled when phase==0 and wait_req=1; phase SHALL hold at 0 and cpu_clk_en SHALL stay 0 until the first cycle with wait_req=0.
REQ-023 A pending speed change SHALL wait through a stall and take effect at the deferred enable.
REQ-024 The module SHALL run a separate timer counter, reloaded with TIMER_DIV-1 and pulsing timer_clk_en when it is 0, independent of speed and of wait_req.
REQ-025 speed_valid and a stall in the same cycle SHALL both be honoured: the request is latched and the stall is applied.

Reset
REQ-026 While reset=1, the module SHALL set state=SLOW, phase=0, timer counter=0, and hold cpu_clk_en, timer_clk_en, speed_ack, speed_busy and speed_fast at 0.
REQ-027 In the first cycle after reset falls, cpu_clk_en and timer_clk_en SHALL both be 1, unless wait_req=1.
REQ-028 A reset during a PEND state SHALL discard the pending request with no ack.

Configuration
REQ-029 With macro CPU_CLOCK_SCHED_WAIT_EN defined, the module SHALL implement stalling per REQ-022/023.
REQ-030 With CPU_CLOCK_SCHED_WAIT_EN undefined, the module SHALL ignore wait_req, never stall, and have no wait logic.

Verification
REQ-031 The bench SHALL cover reset release with no requests -> cpu_clk_en at cycles 0, 12, 24; timer_clk_en at cycles 0 and 3072; speed_fast=0.
REQ-032 The bench SHALL cover speed_valid=1, speed_req=1 at cycle 5 -> speed_busy=1 on cycles 6-12; speed_ack and cpu_clk_en at cycle 12; next enables at 15, 18.
REQ-033 The bench SHALL cover, in fast mode, a slow request and then a second fast request before the boundary -> the second is ignored; one ack; period becomes 12.
REQ-034 The bench SHALL cover, with WAIT_EN, wait_req high in cycles 12-14 in slow mode -> no enable at 12-14; enable at 15; next at 27.
REQ-035 The bench SHALL cover reset asserted while in PEND_FAST -> no ack; after release, slow period 12, speed_busy=0.
REQ-036 The bench SHALL cover, without WAIT_EN, the same wait_req pattern as REQ-034 -> enables unchanged at 12, 24.
